// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// In-order issue/retire controller for the pipelined NAND CPU, placed between
// decode and execute. It keeps an ordered queue of in-flight instructions,
// stalls decode on register / predicate-state (ps) RAW hazards, retires the
// oldest entry on writeback and, on a branch mispredict, squashes every
// younger entry and emits a registered flush + redirect pc to fetch.
//
// Optional build macro:
//   PIPE_HAZARD_WB_BYPASS_EN - the head entry being retired this cycle is
//     ignored by the hazard check, and a full queue that is retiring this
//     cycle may still issue. Undefined: only registered queue state is used.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dec_*                           instruction offered by decode
//   stall, issue, issue_tag         handshake back to decode (combinational)
//   wb_*                            writeback retiring the oldest instruction
//   fb_*                            branch resolution feedback
//   flush, redirect_pc              registered squash pulse and fetch target
//   inflight                        queue occupancy
//   err                             sticky protocol error
// -----------------------------------------------------------------------------
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module pipe_hazard_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int PC_W  = `PC_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [3:0]       dec_src_a,
  input  logic             dec_src_a_en,
  input  logic [3:0]       dec_src_b,
  input  logic             dec_src_b_en,
  input  logic             dec_ps_read,
  input  logic             dec_reg_write,
  input  logic [3:0]       dec_reg_addr,
  input  logic             dec_ps_write,
  output logic             stall,
  output logic             issue,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [3:0]       wb_reg_addr,
  input  logic             wb_ps_write,
  input  logic             fb_valid,
  input  logic             fb_branch,
  input  logic [TAG_W-1:0] fb_tag,
  input  logic [PC_W-1:0]  fb_pc,
  input  logic             fb_predict_taken,
  input  logic             fb_feedback_taken,
  input  logic [PC_W-1:0]  fb_predict_target,
  input  logic [PC_W-1:0]  fb_feedback_target,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [TAG_W:0]   inflight,
  output logic             err
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

  // Queue state
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] rw_q, rw_d;
  logic [DEPTH-1:0] psw_q, psw_d;
  logic [3:0]       addr_q [DEPTH];
  logic [3:0]       addr_d [DEPTH];

  // Output registers
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redir_q, redir_d;
  logic             err_q, err_d;

  // Combinational control
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             bypass_pop_s;
  logic [DEPTH-1:0] live_s;
  logic             hazard_s;
  logic             mispredict_s;
  logic             head_mismatch_s;
  logic [TAG_W-1:0] off_fb_s;
  logic             stall_s;
  logic             issue_s;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == FULL_CNT);
  assign pop_s   = wb_valid & ~empty_s;

`ifdef PIPE_HAZARD_WB_BYPASS_EN
  assign bypass_pop_s = pop_s;
`else
  assign bypass_pop_s = 1'b0;
`endif

  // Distance of the branch from the head; entries further away are younger.
  assign off_fb_s = fb_tag - head_q;

  // A feedback for a slot that holds nothing is ignored (and flagged as error).
  assign mispredict_s = fb_valid & fb_branch & vld_q[fb_tag] &
                        ((fb_predict_taken != fb_feedback_taken) |
                         (fb_feedback_taken & (fb_predict_target != fb_feedback_target)));

  assign head_mismatch_s = (wb_reg_write != rw_q[head_q]) |
                           (wb_reg_addr  != addr_q[head_q]) |
                           (wb_ps_write  != psw_q[head_q]);

  // RAW hazard scan over every live queue entry
  always_comb begin
    live_s   = '0;
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i] = vld_q[i] & ~(bypass_pop_s & (head_q == TAG_W'(i)));
      if (live_s[i]) begin
        if ((rw_q[i] & dec_src_a_en & (addr_q[i] == dec_src_a)) |
            (rw_q[i] & dec_src_b_en & (addr_q[i] == dec_src_b)) |
            (psw_q[i] & dec_ps_read)) begin
          hazard_s = 1'b1;
        end else begin
          hazard_s = hazard_s;
        end
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign stall_s = dec_valid & ((full_s & ~bypass_pop_s) | hazard_s | mispredict_s);
  assign issue_s = dec_valid & ~stall_s;

  // Next-state: retire, error tracking, squash on mispredict, issue
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    rw_d    = rw_q;
    psw_d   = psw_q;
    addr_d  = addr_q;
    err_d   = err_q;
    flush_d = 1'b0;
    redir_d = '0;

    if (pop_s) begin
      head_d        = head_q + TAG_ONE;
      vld_d[head_q] = 1'b0;
      if (head_mismatch_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
    end else if (wb_valid) begin
      err_d = 1'b1;
    end else begin
      head_d = head_q;
    end

    if (fb_valid & ~vld_q[fb_tag]) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    if (mispredict_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((TAG_W'(i) - head_q) > off_fb_s) begin
          vld_d[i] = 1'b0;
        end else begin
          vld_d[i] = vld_d[i];
        end
      end
      tail_d = fb_tag + TAG_ONE;
      // Surviving entries are head..branch inclusive, minus the one retiring.
      count_d = {1'b0, off_fb_s} + CNT_ONE - {{TAG_W{1'b0}}, pop_s};
      flush_d = 1'b1;
      redir_d = fb_feedback_taken ? fb_feedback_target : (fb_pc + PC_ONE);
    end else begin
      if (issue_s) begin
        vld_d[tail_q]  = 1'b1;
        rw_d[tail_q]   = dec_reg_write;
        psw_d[tail_q]  = dec_ps_write;
        addr_d[tail_q] = dec_reg_addr;
        tail_d         = tail_q + TAG_ONE;
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + {{TAG_W{1'b0}}, issue_s} - {{TAG_W{1'b0}}, pop_s};
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      rw_q    <= '0;
      psw_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 4'h0;
      end
      flush_q <= 1'b0;
      redir_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      rw_q    <= rw_d;
      psw_q   <= psw_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
      end
      flush_q <= flush_d;
      redir_q <= redir_d;
      err_q   <= err_d;
    end
  end

  assign stall       = stall_s;
  assign issue       = issue_s;
  assign issue_tag   = tail_q;
  assign flush       = flush_q;
  assign redirect_pc = redir_q;
  assign inflight    = count_q;
  assign err         = err_q;

endmodule
